// File: rtl/core_bus_bridge_if.sv
// Bus-side signal bundle between the core bus bridge (master) and the memory/peripheral fabric (slave).
interface core_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic [3:0]        bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_error;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_error,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_error,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/core_bus_bridge.sv
// Serialises the core's fetch and data ports onto one request/ack bus, data access first,
// with a per-access wait timeout that abandons the access and raises a sticky error.
//
// state   | meaning
// IDLE    | no access in flight; stall follows the core requests
// RAM_ACC | data-port access on the bus, waiting for ack or timeout
// ROM_ACC | fetch-port access on the bus, waiting for ack or timeout
// DONE    | one cycle with stall low so the core advances
module core_bus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [3:0]        rom_write_en,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_write_data,
    output logic [DATA_W-1:0] rom_read_data,
    input  logic              ram_en,
    input  logic [3:0]        ram_write_en,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_write_data,
    output logic [DATA_W-1:0] ram_read_data,
    output logic              stall,
    core_bus_bridge_if.master bus
);
    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    typedef enum logic [1:0] {IDLE, RAM_ACC, ROM_ACC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              in_acc, timeout_hit, acc_done;
    logic              bus_req_c;
    logic [3:0]        bus_we_c;
    logic [ADDR_W-1:0] bus_addr_c;
    logic [DATA_W-1:0] bus_wdata_c;
    logic              bus_error_q;

    assign in_acc      = (state == RAM_ACC) || (state == ROM_ACC);
    // An ack arriving in the timeout cycle wins, so the timeout is only taken without ack.
    assign timeout_hit = in_acc && !bus.bus_ack && (wait_cnt == CNT_W'(TIMEOUT));
    assign acc_done    = in_acc && (bus.bus_ack || timeout_hit);

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        bus_req_c   = 1'b0;
        bus_we_c    = 4'b0;
        bus_addr_c  = '0;
        bus_wdata_c = '0;
        case (state)
            IDLE: begin
                if (ram_en) begin
                    state_nxt = RAM_ACC;
                    stall     = 1'b1;
                end else if (rom_en) begin
                    state_nxt = ROM_ACC;
                    stall     = 1'b1;
                end
            end
            RAM_ACC: begin
                stall       = 1'b1;
                bus_req_c   = 1'b1;
                bus_we_c    = ram_write_en;
                bus_addr_c  = ram_addr;
                bus_wdata_c = ram_write_data;
                if (acc_done) state_nxt = rom_en ? ROM_ACC : DONE;
            end
            ROM_ACC: begin
                stall       = 1'b1;
                bus_req_c   = 1'b1;
                bus_we_c    = rom_write_en;
                bus_addr_c  = rom_addr;
                bus_wdata_c = rom_write_data;
                if (acc_done) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Cleared whenever an access ends so a following ROM_ACC starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (!in_acc || acc_done) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_read_data <= '0;
            rom_read_data <= '0;
            bus_error_q   <= 1'b0;
        end else begin
            if (state == RAM_ACC) begin
                if (bus.bus_ack && (ram_write_en == 4'b0)) ram_read_data <= bus.bus_rdata;
                else if (timeout_hit)                      ram_read_data <= '0;
            end
            if (state == ROM_ACC) begin
                if (bus.bus_ack && (rom_write_en == 4'b0)) rom_read_data <= bus.bus_rdata;
                else if (timeout_hit)                      rom_read_data <= '0;
            end
            if (timeout_hit) bus_error_q <= 1'b1;
        end
    end

    assign bus.bus_req   = bus_req_c;
    assign bus.bus_we    = bus_we_c;
    assign bus.bus_addr  = bus_addr_c;
    assign bus.bus_wdata = bus_wdata_c;
    assign bus.bus_error = bus_error_q;
endmodule

// File: tb/tb_core_bus_bridge.sv
// Scoreboard bench for core_bus_bridge: directed accesses, a latency-programmed bus responder,
// and a monitor that checks bus beats and end-of-access results from expectation queues.
`timescale 1ns/1ps
module tb_core_bus_bridge;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en, ram_en, stall;
    logic [3:0]  rom_write_en, ram_write_en;
    logic [31:0] rom_addr, rom_write_data, rom_read_data;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;

    core_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    core_bus_bridge #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data), .rom_read_data(rom_read_data),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .stall(stall), .bus(bif)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } bus_exp_t;
    typedef struct { int lat; logic [31:0] rdata; } resp_t;
    typedef struct { logic [31:0] rom_rd; logic [31:0] ram_rd; logic err; int stalls; } done_t;

    bus_exp_t bus_q[$];
    resp_t    resp_q[$];
    done_t    done_q[$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int wait_n = 0;
    bit mon_en = 1'b1;
    bit stray = 1'b0;
    logic [31:0] stray_data = 32'h0;
    logic prev_stall = 1'b0;
    logic [31:0] exp_rom = 32'h0;
    logic [31:0] exp_ram = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus responder: acks after resp_q[0].lat wait cycles of bus_req.
    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'h0;
            if (stray) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = stray_data;
            end else if (bif.bus_req && resp_q.size() > 0) begin
                if (wait_n == resp_q[0].lat) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = resp_q[0].rdata;
                    void'(resp_q.pop_front());
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // Monitor: bus beats are checked every cycle they are presented; DONE is the stall 1->0 edge.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                stall_cnt = 0;
            end else begin
                if (bif.bus_req) begin
                    if (bus_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bus_unexpected_req actual=req required=none addr=%h", bif.bus_addr);
                    end else begin
                        chk("bus_addr", bif.bus_addr, bus_q[0].addr);
                        chk("bus_we", {28'h0, bif.bus_we}, {28'h0, bus_q[0].we});
                        chk("bus_wdata", bif.bus_wdata, bus_q[0].wdata);
                        if (bif.bus_ack) void'(bus_q.pop_front());
                    end
                end
                if (stall) stall_cnt++;
                if (prev_stall && !stall) begin
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL done_unexpected actual=done required=none");
                    end else begin
                        d = done_q.pop_front();
                        chk("rom_read_data", rom_read_data, d.rom_rd);
                        chk("ram_read_data", ram_read_data, d.ram_rd);
                        chk("bus_error", {31'h0, bif.bus_error}, {31'h0, d.err});
                        chk("stall_cycles", stall_cnt, d.stalls);
                        chk("done_bus_req", {31'h0, bif.bus_req}, 32'h0);
                    end
                    stall_cnt = 0;
                end
            end
            prev_stall = stall;
        end
    end

    task automatic run_access(input logic r_en, input logic [3:0] r_we, input logic [31:0] r_addr,
                              input logic [31:0] r_wd, input logic f_en, input logic [31:0] f_addr);
        int start;
        bit got;
        @(posedge clk); #1;
        ram_en = r_en; ram_write_en = r_we; ram_addr = r_addr; ram_write_data = r_wd;
        rom_en = f_en; rom_addr = f_addr;
        start = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk); #1;
            if (done_cnt != start) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL done_wait actual=no_done required=done_within_600");
        end
        ram_en = 1'b0; rom_en = 1'b0; ram_write_en = 4'h0;
        @(posedge clk); #1;
        chk("idle_stall", {31'h0, stall}, 32'h0);
        chk("idle_bus_req", {31'h0, bif.bus_req}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        rom_en = 1'b0; ram_en = 1'b0; rom_write_en = 4'h0; ram_write_en = 4'h0;
        rom_addr = 32'h0; ram_addr = 32'h0; rom_write_data = 32'h0; ram_write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_rd", rom_read_data, 32'h0);
        chk("rst_ram_rd", ram_read_data, 32'h0);
        chk("rst_bus_error", {31'h0, bif.bus_error}, 32'h0);
        chk("rst_bus_req", {31'h0, bif.bus_req}, 32'h0);
        chk("rst_bus_addr", bif.bus_addr, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;

        // Fetch only, one wait cycle then ack.
        resp_q.push_back('{1, 32'h24010001});
        bus_q.push_back('{32'hBFC00000, 4'h0, 32'h0});
        exp_rom = 32'h24010001;
        done_q.push_back('{exp_rom, exp_ram, 1'b0, 3});
        run_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC00000);

        // Load plus fetch, immediate acks: data port goes first.
        resp_q.push_back('{0, 32'h11111111});
        resp_q.push_back('{0, 32'h22222222});
        bus_q.push_back('{32'h80000010, 4'h0, 32'h0});
        bus_q.push_back('{32'hBFC00004, 4'h0, 32'h0});
        exp_ram = 32'h11111111; exp_rom = 32'h22222222;
        done_q.push_back('{exp_rom, exp_ram, 1'b0, 3});
        run_access(1'b1, 4'h0, 32'h80000010, 32'h0, 1'b1, 32'hBFC00004);

        // Store: read data ignored, ram_read_data unchanged.
        resp_q.push_back('{2, 32'hCAFECAFE});
        bus_q.push_back('{32'h80000020, 4'b0011, 32'hDEADBEEF});
        done_q.push_back('{exp_rom, exp_ram, 1'b0, 4});
        run_access(1'b1, 4'b0011, 32'h80000020, 32'hDEADBEEF, 1'b0, 32'h0);

        // Ack coincides with the timeout cycle: ack wins.
        resp_q.push_back('{TIMEOUT, 32'h00000005});
        bus_q.push_back('{32'hBFC00008, 4'h0, 32'h0});
        exp_rom = 32'h5;
        done_q.push_back('{exp_rom, exp_ram, 1'b0, TIMEOUT + 2});
        run_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC00008);

        // Reset in the middle of a data access, then a stray ack.
        mon_en = 1'b0;
        resp_q.push_back('{9999, 32'h0});
        bus_q.push_back('{32'h80000030, 4'h0, 32'h0});
        @(posedge clk); #1;
        ram_en = 1'b1; ram_addr = 32'h80000030;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_bus_req", {31'h0, bif.bus_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_req", {31'h0, bif.bus_req}, 32'h0);
        chk("mid_rst_bus_addr", bif.bus_addr, 32'h0);
        chk("mid_rst_bus_wdata", bif.bus_wdata, 32'h0);
        chk("mid_rst_ram_rd", ram_read_data, 32'h0);
        chk("mid_rst_rom_rd", rom_read_data, 32'h0);
        ram_en = 1'b0; ram_addr = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_q.delete();
        bus_q.delete();
        exp_rom = 32'h0; exp_ram = 32'h0;
        stray_data = 32'hBAD0BAD0;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_bus_req", {31'h0, bif.bus_req}, 32'h0);
            chk("stray_ram_rd", ram_read_data, 32'h0);
            chk("stray_rom_rd", rom_read_data, 32'h0);
            chk("stray_stall", {31'h0, stall}, 32'h0);
        end
        chk("stray_bus_error", {31'h0, bif.bus_error}, 32'h0);
        mon_en = 1'b1;

        // Fetch with immediate ack so the timeout below has something to clear.
        resp_q.push_back('{0, 32'h13572468});
        bus_q.push_back('{32'hBFC00010, 4'h0, 32'h0});
        exp_rom = 32'h13572468;
        done_q.push_back('{exp_rom, exp_ram, 1'b0, 2});
        run_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC00010);

        // Timeout: no ack ever, read data forced to 0 and bus_error set.
        resp_q.push_back('{9999, 32'hFFFFFFFF});
        bus_q.push_back('{32'hBFC0000C, 4'h0, 32'h0});
        exp_rom = 32'h0;
        done_q.push_back('{exp_rom, exp_ram, 1'b1, TIMEOUT + 2});
        run_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC0000C);
        resp_q.delete();
        bus_q.delete();

        // bus_error stays set across a later good access.
        resp_q.push_back('{0, 32'hA5A5A5A5});
        bus_q.push_back('{32'h80000040, 4'h0, 32'h0});
        exp_ram = 32'hA5A5A5A5;
        done_q.push_back('{exp_rom, exp_ram, 1'b1, 2});
        run_access(1'b1, 4'h0, 32'h80000040, 32'h0, 1'b0, 32'h0);

        chk("done_q_drained", done_q.size(), 32'h0);
        chk("bus_q_drained", bus_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
